// File: rtl/hd44780_bus_sequencer.sv
// rtl/hd44780_bus_sequencer.sv - HD44780 8-bit parallel bus write sequencer
//
// Accepts one byte write at a time (valid/ready) and plays it onto the LCD
// bus as SETUP -> E PULSE -> HOLD -> execution WAIT, each phase counted in
// clk cycles. Clear/home commands (rs=0, 0x01..0x03) get the long wait.
//
// Optional feature macro: HD44780_INIT_EN
//   defined   : after reset wait T_POWERUP, then write the 8-bit init
//               sequence 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C before
//               raising init_done and accepting requests.
//   undefined : no init logic, init_done is held at 1.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   requester offers a write
//   in_ready   out  sequencer accepts a write (IDLE and init_done)
//   in_rs      in   0 = command, 1 = data
//   in_data    in   [7:0] byte to write
//   lcd_rs     out  registered register-select
//   lcd_rw     out  always 0 (write only)
//   lcd_e      out  registered enable strobe
//   lcd_db     out  [7:0] registered data bus
//   init_done  out  init sequence complete

module hd44780_bus_sequencer #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 12,
  parameter int unsigned T_EXEC    = 1000,
  parameter int unsigned T_LONG    = 41000,
  parameter int unsigned T_POWERUP = 400000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       init_done
);

  function automatic int unsigned max_t(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The counter only ever holds N-1 for the largest phase, so it needs
  // enough bits for T_MAX-1; keep at least one bit.
  localparam int unsigned T_MAX = max_t(max_t(max_t(T_SETUP, T_PULSE), max_t(T_HOLD, T_EXEC)),
                                        max_t(T_LONG, T_POWERUP));
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);
`ifdef HD44780_INIT_EN
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
`ifdef HD44780_INIT_EN
    ,
    S_INIT_WAIT,
    S_INIT_LOAD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_db_q, lcd_db_d;
  logic             lcd_e_q, lcd_e_d;
  logic             in_ready_q, in_ready_d;
  logic             init_done_q, init_done_d;
  logic             long_wait;

`ifdef HD44780_INIT_EN
  logic [2:0]       idx_q, idx_d;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h30;
      3'd1:    return 8'h30;
      3'd2:    return 8'h30;
      3'd3:    return 8'h38;
      3'd4:    return 8'h08;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      default: return 8'h0C;
    endcase
  endfunction
`endif

  // lcd_rs_q/lcd_db_q double as the captured request, so the wait choice
  // looks at them directly. The very first init write (0x30) also needs
  // the long wait even though it is not a clear/home command.
  always_comb begin
    long_wait = !lcd_rs_q && ((lcd_db_q == 8'h01) || (lcd_db_q == 8'h02) || (lcd_db_q == 8'h03));
`ifdef HD44780_INIT_EN
    if (!init_done_q && (idx_q == 3'd0)) begin
      long_wait = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_db_d    = lcd_db_q;
    init_done_d = init_done_q;
`ifdef HD44780_INIT_EN
    idx_d       = idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          lcd_rs_d = in_rs;
          lcd_db_d = in_data;
          state_d  = S_SETUP;
          cnt_d    = LD_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = long_wait ? LD_LONG : LD_EXEC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
`ifdef HD44780_INIT_EN
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 3'd7) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_INIT_LOAD;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef HD44780_INIT_EN
      S_INIT_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_INIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Behaves like an internal transfer: load the next init command
      // into the bus registers and start its SETUP phase.
      S_INIT_LOAD: begin
        lcd_rs_d = 1'b0;
        lcd_db_d = init_cmd(idx_q);
        state_d  = S_SETUP;
        cnt_d    = LD_SETUP;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus outputs are registered in step with the state, so lcd_e is high
    // for exactly the cycles spent in PULSE.
    lcd_e_d    = (state_d == S_PULSE);
    in_ready_d = (state_d == S_IDLE) && init_done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef HD44780_INIT_EN
      state_q     <= S_INIT_WAIT;
      cnt_q       <= LD_POWERUP;
      init_done_q <= 1'b0;
      idx_q       <= 3'd0;
`else
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      init_done_q <= 1'b1;
`endif
      lcd_rs_q    <= 1'b0;
      lcd_db_q    <= 8'h00;
      lcd_e_q     <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
`ifdef HD44780_INIT_EN
      idx_q       <= idx_d;
`endif
      lcd_rs_q    <= lcd_rs_d;
      lcd_db_q    <= lcd_db_d;
      lcd_e_q     <= lcd_e_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_db    = lcd_db_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_hd44780_bus_sequencer.sv
// tb/tb_hd44780_bus_sequencer.sv - self-checking bench for hd44780_bus_sequencer

module tb_hd44780_bus_sequencer;

  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_PULSE   = 4;
  localparam int unsigned T_HOLD    = 3;
  localparam int unsigned T_EXEC    = 10;
  localparam int unsigned T_LONG    = 50;
  localparam int unsigned T_POWERUP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       init_done;

  int checks = 0;
  int failures = 0;

  // E rising edges seen by the monitor, with the bus value at that moment.
  logic [7:0] cap_db[$];
  logic       cap_rs[$];
  logic       e_prev = 1'b0;

  always #5 clk = ~clk;

  hd44780_bus_sequencer #(
    .T_SETUP  (T_SETUP),
    .T_PULSE  (T_PULSE),
    .T_HOLD   (T_HOLD),
    .T_EXEC   (T_EXEC),
    .T_LONG   (T_LONG),
    .T_POWERUP(T_POWERUP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_db   (lcd_db),
    .init_done(init_done)
  );

  always @(posedge clk) begin
    #1;
    if (lcd_e && !e_prev) begin
      cap_db.push_back(lcd_db);
      cap_rs.push_back(lcd_rs);
    end
    e_prev = lcd_e;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample index c counts clock edges after the transfer edge (c=0 is the
  // sample just after the transfer). SETUP occupies c=0..1, PULSE c=2..5,
  // HOLD c=6..8, WAIT c=9..(8+wait), so in_ready returns at
  // c = T_SETUP+T_PULSE+T_HOLD+wait = 19 (T_EXEC) or 59 (T_LONG).
  task automatic write_check(input logic rs, input logic [7:0] d, input int exp_rdy, input string nm);
    int  waitc;
    int  e_first;
    int  e_len;
    int  rdy_at;
    int  bus_ok;
    waitc = 0;
    while (!in_ready && waitc < 500) begin
      tick();
      waitc++;
    end
    chk({nm, "_ready_before"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    tick();
    // Garbage on the request bus while busy must not reach the LCD bus.
    in_valid = 1'b0;
    in_rs    = ~rs;
    in_data  = ~d;
    e_first  = -1;
    e_len    = 0;
    rdy_at   = -1;
    bus_ok   = 1;
    for (int c = 0; c < exp_rdy + 20; c++) begin
      if (c > 0) tick();
      if (lcd_e === 1'b1) begin
        if (e_first < 0) e_first = c;
        e_len++;
      end
      if (lcd_db !== d || lcd_rs !== rs || lcd_rw !== 1'b0) bus_ok = 0;
      if (in_ready === 1'b1) begin
        rdy_at = c;
        break;
      end
    end
    chk({nm, "_e_start"}, e_first, T_SETUP);
    chk({nm, "_e_len"}, e_len, T_PULSE);
    chk({nm, "_bus_held"}, bus_ok, 1);
    chk({nm, "_ready_return"}, rdy_at, exp_rdy);
  endtask

`ifdef HD44780_INIT_EN
  task automatic run_init(input string nm);
    logic [7:0] exp_seq[8];
    int         early_ready;
    int         last_e;
    int         done_at;
    int         rs_bad;
    exp_seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    cap_db.delete();
    cap_rs.delete();
    early_ready = 0;
    last_e  = -1;
    done_at = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (lcd_e === 1'b1) last_e = c;
      if (init_done === 1'b1) begin
        done_at = c;
        break;
      end
      if (in_ready !== 1'b0) early_ready++;
    end
    chk({nm, "_init_done_rose"}, int'(done_at >= 0), 1);
    chk({nm, "_ready_during_init"}, early_ready, 0);
    chk({nm, "_ready_with_done"}, int'(in_ready), 1);
    chk({nm, "_pulse_count"}, cap_db.size(), 8);
    // Last PULSE sample, then HOLD and the final WAIT, then IDLE.
    chk({nm, "_done_gap"}, done_at - last_e, T_HOLD + T_EXEC + 1);
    rs_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < cap_db.size()) begin
        chk($sformatf("%s_init_byte%0d", nm, i), int'(cap_db[i]), int'(exp_seq[i]));
        if (cap_rs[i] !== 1'b0) rs_bad++;
      end
    end
    chk({nm, "_init_rs"}, rs_bad, 0);
  endtask
`endif

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_rdy;
    string      name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] b2b[3];
    int         ptr;
    int         n_rdy;
    int         e_seen;
    logic       rdy_seen;

    vecs[0] = '{1'b1, 8'h41, 19, "data_41"};
    vecs[1] = '{1'b0, 8'h01, 59, "cmd_clear"};
    vecs[2] = '{1'b0, 8'h80, 19, "cmd_80"};
    vecs[3] = '{1'b0, 8'h02, 59, "cmd_home"};
    vecs[4] = '{1'b0, 8'h03, 59, "cmd_03"};
    vecs[5] = '{1'b0, 8'h04, 19, "cmd_04"};
    vecs[6] = '{1'b1, 8'h01, 19, "data_01"};
    vecs[7] = '{1'b0, 8'h00, 19, "cmd_00"};

    // Reset state, held across several edges.
    #23;
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_db", int'(lcd_db), 0);
    chk("rst_in_ready", int'(in_ready), 0);
`ifdef HD44780_INIT_EN
    chk("rst_init_done", int'(init_done), 0);
`else
    chk("rst_init_done", int'(init_done), 1);
`endif
    #5;
    rst = 1'b1;
    tick();
`ifdef HD44780_INIT_EN
    chk("first_cycle_ready", int'(in_ready), 0);
    run_init("boot");
`else
    chk("first_cycle_ready", int'(in_ready), 1);
`endif

    for (int i = 0; i < 8; i++) begin
      write_check(vecs[i].rs, vecs[i].data, vecs[i].exp_rdy, vecs[i].name);
    end

    // Back-to-back: in_valid stays high, data advances only after a transfer.
    b2b = '{8'hA5, 8'h5A, 8'hC3};
    cap_db.delete();
    cap_rs.delete();
    ptr   = 0;
    n_rdy = 0;
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = b2b[0];
    for (int c = 0; c < 300 && ptr < 3; c++) begin
      rdy_seen = in_ready;
      tick();
      if (rdy_seen) begin
        n_rdy++;
        ptr++;
        if (ptr < 3) in_data = b2b[ptr];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_transfers", ptr, 3);
    for (int c = 0; c < 40; c++) tick();
    chk("b2b_pulses", cap_db.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < cap_db.size()) chk($sformatf("b2b_byte%0d", i), int'(cap_db[i]), int'(b2b[i]));
    end

    // Reset in the middle of an E pulse: E must drop without a clock edge.
    e_seen = 0;
    while (!in_ready && e_seen < 500) begin
      tick();
      e_seen++;
    end
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    e_seen = 0;
    for (int c = 0; c < 20 && !e_seen; c++) begin
      tick();
      if (lcd_e === 1'b1) e_seen = 1;
    end
    chk("abort_reached_pulse", e_seen, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_lcd_e", int'(lcd_e), 0);
    chk("abort_lcd_db", int'(lcd_db), 0);
    chk("abort_lcd_rs", int'(lcd_rs), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    #2;
    rst = 1'b1;
    tick();
`ifdef HD44780_INIT_EN
    chk("restart_ready", int'(in_ready), 0);
    run_init("restart");
`else
    chk("restart_ready", int'(in_ready), 1);
    e_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (lcd_e !== 1'b0) e_seen++;
    end
    chk("restart_no_stale_pulse", e_seen, 0);
`endif
    write_check(1'b1, 8'h42, 19, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hd44780_bus_sequencer.md
HD44780_BUS_SEQUENCER -- requirements
Module: hd44780_bus_sequencer

Interface
REQ-001 The block SHALL have parameter T_SETUP, default 2: clk cycles RS/DB valid before E rises.
REQ-002 The block SHALL have parameter T_PULSE, default 12: clk cycles E is high.
REQ-003 The block SHALL have parameter T_HOLD, default 12: clk cycles RS/DB held after E falls.
REQ-004 The block SHALL have parameter T_EXEC, default 1000: post-write wait for normal commands and data.
REQ-005 The block SHALL have parameter T_LONG, default 41000: post-write wait for clear/home commands.
REQ-006 The block SHALL have parameter T_POWERUP, default 400000: wait after reset before the first init write.
REQ-007 The block SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1: requester offers a write.
REQ-010 The block SHALL have port in_ready, output, 1: sequencer accepts a write.
REQ-011 The block SHALL have port in_rs, input, 1: 0 = command, 1 = data.
REQ-012 The block SHALL have port in_data, input, 8: byte to write.
REQ-013 The block SHALL have ports lcd_rs/lcd_rw/lcd_e, outputs, 1 each, and lcd_db, output, 8: registered LCD bus.
REQ-014 The block SHALL have port init_done, output, 1: high once the init sequence has completed.

Function
REQ-015 The block SHALL implement states IDLE, SETUP, PULSE, HOLD, WAIT (plus INIT_WAIT, INIT_LOAD when init is compiled in).
REQ-016 The block SHALL drive in_ready high only in IDLE with init_done=1; transfer occurs when in_valid&in_ready on a rising edge.
REQ-017 The block SHALL capture in_rs/in_data on transfer and enter SETUP on the next cycle; in_ready falls the cycle after transfer.
REQ-018 The block SHALL hold each timed phase for exactly its parameter count (load N-1, count to 0); all T_* are ≥1.
REQ-019 The block SHALL drive, in SETUP: lcd_e=0 with captured lcd_rs/lcd_db; in PULSE: lcd_e=1; in HOLD: lcd_e=0 with lcd_rs/lcd_db unchanged.
REQ-020 The block SHALL use T_LONG in WAIT when rs=0 and data is 0x01, 0x02 or 0x03, and T_EXEC otherwise; WAIT then returns to IDLE.
REQ-021 The block SHALL keep lcd_rw=0 at all times, and keep lcd_rs/lcd_db at their last value outside SETUP/PULSE/HOLD.
REQ-022 The block SHALL size its counter to the largest T_* parameter with no wrap.
REQ-023 The block SHALL ignore in_valid, in_rs and in_data while in_ready=0; no write is queued or dropped silently.

Reset
REQ-024 On rst low the block SHALL immediately force lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00 and in_ready=0, and abort any write mid-pulse.
REQ-025 On rst low the block SHALL force init_done=0 when HD44780_INIT_EN is defined, and init_done=1 otherwise.
REQ-026 The first state after rst release SHALL be INIT_WAIT with HD44780_INIT_EN defined, and IDLE otherwise.

Configuration
REQ-027 With macro HD44780_INIT_EN defined, the block SHALL wait T_POWERUP, then autonomously write commands 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C.
REQ-028 Each init write SHALL use the REQ-019/REQ-020 bus timing; after the first 0x30 the wait SHALL be T_LONG instead of T_EXEC.
REQ-029 After the 0x0C WAIT completes, the block SHALL set init_done=1 and enter IDLE.
REQ-030 With HD44780_INIT_EN undefined, the block SHALL contain no init logic; in_ready=1 in the first cycle after rst release.

Verification
Bench parameters: T_SETUP=2, T_PULSE=4, T_HOLD=3, T_EXEC=10, T_LONG=50, T_POWERUP=20.
REQ-031 Data write, init disabled: transfer rs=1, 0x41 -> E high exactly 4 cycles starting 3 cycles after transfer; DB=0x41 and RS=1 for 9 cycles; in_ready high again 20 cycles after transfer.
REQ-032 Clear command 0x01 (rs=0) -> in_ready returns 60 cycles after transfer; command 0x80 -> 20 cycles.
REQ-033 Back-to-back writes with in_valid held high -> exactly one transfer per in_ready pulse; no byte duplicated or lost.
REQ-034 Init enabled -> exactly 8 E pulses carrying 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C with RS=0; init_done rises after the final WAIT; in_ready=0 until then.
REQ-035 rst asserted during PULSE -> lcd_e=0 in the same cycle with no clock edge required; after release, the sequence restarts from the REQ-026 state.
